tpu_avalon_ctrl: RTL and testbench
==================================

TPU_AVALON_CTRL -- requirements
Module: tpu_avalon_ctrl

Interface
REQ-001 Parameters SHALL be:
- DATA_WIDTH, 64, Avalon data width.
- WIDTH_HEIGHT, 16, systolic array dimension.
- MEM_AW, 8, per-memory address width.
- RST_CYCLES, 4, core-reset pulse length.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  sole clock.
- reset  in  1  asynchronous, active-low.
- slave_address  in  MEM_AW+2  [top 2] = region, [MEM_AW-1:0] = offset.
- slave_read, slave_write  in  1  Avalon strobes.
- slave_writedata  in  DATA_WIDTH  write data.
- slave_readdata  out  DATA_WIDTH  read data.
- slave_readdatavalid  out  1  read data qualifier.
- slave_waitrequest  out  1  tied 0.
- in_wr_en, wt_wr_en  out  WIDTH_HEIGHT  replicated memory write enables.
- mem_wr_addr  out  WIDTH_HEIGHT*MEM_AW  replicated offset.
- mem_wr_data  out  WIDTH_HEIGHT*8  slave_writedata[7:0] replicated.
- out_rd_en  out  WIDTH_HEIGHT  output memory read enables.
- out_rd_addr  out  WIDTH_HEIGHT*MEM_AW  replicated offset.
- out_rd_data  in  DATA_WIDTH  core output data, valid 1 cycle after out_rd_en.
- tpu_reset, fill_fifo, drain_fifo, active  out  1  core controls.
- in_base, wt_base, out_base  out  WIDTH_HEIGHT*MEM_AW  replicated base addresses.
- mem_to_fifo_done, fifo_to_arr_done, output_done  in  1  core completion pulses.
- irq  out  1  level interrupt.

Function
REQ-003 Regions SHALL be: 00 control, 01 input memory, 10 weight memory, 11 output memory.
REQ-004 Control offsets SHALL be: 0 CMD (write), 1 STATUS (read), 2 CYCLES (read), 3 IRQ_EN (read/write, bit 0).
REQ-005 Memory write enables and write data SHALL be combinational from the slave write strobe and address (zero latency); a write to region 11 SHALL be ignored.
REQ-006 Every read SHALL have a fixed latency of 2 cycles: slave_readdatavalid is high exactly 2 cycles after slave_read. A read of region 01 or 10 SHALL return 0.
REQ-007 CMD[3:0] opcodes SHALL be: 1111 RESET, 0001 FILL (wt_base <= CMD[11:4]), 0010 DRAIN, 0011 MULTIPLY (in_base <= CMD[11:4], out_base <= CMD[19:12]), 0100 RUN (loads all three bases, then performs FILL, DRAIN, MULTIPLY in sequence). Other opcodes SHALL set err.
REQ-008 FSM states SHALL be IDLE, RST, FILL, DRAIN, MULT, with transitions:
- IDLE -> RST, FILL, DRAIN or MULT on the matching opcode.
- RST -> IDLE after RST_CYCLES cycles.
- FILL -> IDLE on mem_to_fifo_done, or -> DRAIN if in RUN.
- DRAIN -> IDLE on fifo_to_arr_done, or -> MULT if in RUN.
- MULT -> IDLE on output_done.
REQ-009 Control outputs SHALL be registered and one-hot with the state: tpu_reset=RST, fill_fifo=FILL, drain_fifo=DRAIN, active=MULT.
REQ-010 A non-RESET command SHALL be ignored while the FSM is not in IDLE, and SHALL set err.
REQ-011 RESET SHALL be accepted in any state; it aborts the current operation, clears the bases, and enters RST on the next cycle.
REQ-012 STATUS SHALL be {busy (bit 0), done (bit 1), err (bit 2), state (bits 6:4)}.
- done is set when the final step returns to IDLE.
- done and err are cleared by any accepted command or by a write to STATUS.
REQ-013 CYCLES SHALL reset to 0 on any accepted command, increment each cycle while busy, and saturate at all-ones.
REQ-014 irq SHALL equal done AND IRQ_EN.
REQ-015 A done pulse that arrives in a state other than its matching state SHALL be ignored.

Reset
REQ-016 While reset is low, all of the following SHALL be 0 and the FSM SHALL be in IDLE: state, bases, control outputs, STATUS, CYCLES, IRQ_EN, slave_readdata, slave_readdatavalid.
REQ-017 Reset SHALL assert asynchronously and deassert synchronously to clk.

Verification
REQ-018 Write region 01 offset 0x05 with data 0xAB -> in_wr_en all-ones, every lane of mem_wr_addr = 0x05, every lane of mem_wr_data = 0xAB in the same cycle; wt_wr_en = 0.
REQ-019 CMD = 0x0_02_01_4 (RUN) -> fill_fifo high with wt_base lanes = 0x01; on mem_to_fifo_done, drain_fifo; on fifo_to_arr_done, active with in_base = 0x01, out_base = 0x02; on output_done, STATUS = 0x2 and irq = IRQ_EN.
REQ-020 CMD FILL while in MULT -> state unchanged, err = 1; then CMD RESET -> tpu_reset high for 4 cycles, then IDLE with STATUS = 0.
REQ-021 Read of STATUS at cycle t -> slave_readdatavalid at t+2 only; read of region 11 offset 3 -> out_rd_en at t, and out_rd_data sampled at t+1 is returned at t+2.
REQ-022 Reset asserted mid-DRAIN -> drain_fifo = 0 immediately, without waiting for a clock edge; after release, CYCLES = 0 and the FSM is in IDLE.

Source files
------------

// File: rtl/tpu_avalon_ctrl.sv
// Avalon-MM slave front end for the systolic-array TPU core: memory write fan-out,
// fixed-latency reads, command FSM driving the core control strobes, status/cycle/irq registers.
module tpu_avalon_ctrl #(
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned WIDTH_HEIGHT = 16,
  parameter int unsigned MEM_AW       = 8,
  parameter int unsigned RST_CYCLES   = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [MEM_AW+1:0]              slave_address,
  input  logic                           slave_read,
  input  logic                           slave_write,
  input  logic [DATA_WIDTH-1:0]          slave_writedata,
  output logic [DATA_WIDTH-1:0]          slave_readdata,
  output logic                           slave_readdatavalid,
  output logic                           slave_waitrequest,
  output logic [WIDTH_HEIGHT-1:0]        in_wr_en,
  output logic [WIDTH_HEIGHT-1:0]        wt_wr_en,
  output logic [WIDTH_HEIGHT*MEM_AW-1:0] mem_wr_addr,
  output logic [WIDTH_HEIGHT*8-1:0]      mem_wr_data,
  output logic [WIDTH_HEIGHT-1:0]        out_rd_en,
  output logic [WIDTH_HEIGHT*MEM_AW-1:0] out_rd_addr,
  input  logic [DATA_WIDTH-1:0]          out_rd_data,
  output logic                           tpu_reset,
  output logic                           fill_fifo,
  output logic                           drain_fifo,
  output logic                           active,
  output logic [WIDTH_HEIGHT*MEM_AW-1:0] in_base,
  output logic [WIDTH_HEIGHT*MEM_AW-1:0] wt_base,
  output logic [WIDTH_HEIGHT*MEM_AW-1:0] out_base,
  input  logic                           mem_to_fifo_done,
  input  logic                           fifo_to_arr_done,
  input  logic                           output_done,
  output logic                           irq
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RST   = 3'd1,
    S_FILL  = 3'd2,
    S_DRAIN = 3'd3,
    S_MULT  = 3'd4
  } state_e;

  localparam logic [3:0] OP_RESET = 4'hF;
  localparam logic [3:0] OP_FILL  = 4'h1;
  localparam logic [3:0] OP_DRAIN = 4'h2;
  localparam logic [3:0] OP_MULT  = 4'h3;
  localparam logic [3:0] OP_RUN   = 4'h4;

  localparam logic [MEM_AW-1:0] OFF_CMD    = MEM_AW'(0);
  localparam logic [MEM_AW-1:0] OFF_STATUS = MEM_AW'(1);
  localparam logic [MEM_AW-1:0] OFF_CYCLES = MEM_AW'(2);
  localparam logic [MEM_AW-1:0] OFF_IRQEN  = MEM_AW'(3);

  localparam int unsigned RST_CW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  // Reset asserts asynchronously but is released only after two clean clock edges.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync_q <= '0;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  logic [1:0]        region;
  logic [MEM_AW-1:0] offset;
  logic              cmd_wr, status_wr, irqen_wr;
  logic [3:0]        opcode;
  logic [MEM_AW-1:0] base_a, base_b;

  assign region    = slave_address[MEM_AW+1:MEM_AW];
  assign offset    = slave_address[MEM_AW-1:0];
  assign cmd_wr    = slave_write && (region == 2'b00) && (offset == OFF_CMD);
  assign status_wr = slave_write && (region == 2'b00) && (offset == OFF_STATUS);
  assign irqen_wr  = slave_write && (region == 2'b00) && (offset == OFF_IRQEN);
  assign opcode    = slave_writedata[3:0];
  assign base_a    = slave_writedata[MEM_AW+3:4];
  assign base_b    = slave_writedata[2*MEM_AW+3:MEM_AW+4];

  logic unused_wdata;
  assign unused_wdata = ^slave_writedata[DATA_WIDTH-1:2*MEM_AW+4];

  assign slave_waitrequest = 1'b0;
  assign in_wr_en    = {WIDTH_HEIGHT{slave_write && (region == 2'b01)}};
  assign wt_wr_en    = {WIDTH_HEIGHT{slave_write && (region == 2'b10)}};
  assign mem_wr_addr = {WIDTH_HEIGHT{offset}};
  assign mem_wr_data = {WIDTH_HEIGHT{slave_writedata[7:0]}};
  assign out_rd_en   = {WIDTH_HEIGHT{slave_read && (region == 2'b11)}};
  assign out_rd_addr = {WIDTH_HEIGHT{offset}};

  state_e                state_q, state_d;
  logic                  run_q, run_d;
  logic [RST_CW-1:0]     rst_cnt_q, rst_cnt_d;
  logic [MEM_AW-1:0]     in_base_q, in_base_d, wt_base_q, wt_base_d, out_base_q, out_base_d;
  logic                  done_q, done_d, err_q, err_d;
  logic                  irq_en_q, irq_en_d;
  logic [DATA_WIDTH-1:0] cycles_q, cycles_d;
  logic                  accepted;

  // Priority: STATUS-write clear < completion set < command handling (RESET overrides all).
  always_comb begin
    state_d    = state_q;
    run_d      = run_q;
    rst_cnt_d  = rst_cnt_q;
    in_base_d  = in_base_q;
    wt_base_d  = wt_base_q;
    out_base_d = out_base_q;
    done_d     = done_q;
    err_d      = err_q;
    irq_en_d   = irqen_wr ? slave_writedata[0] : irq_en_q;
    accepted   = 1'b0;

    if (status_wr) begin
      done_d = 1'b0;
      err_d  = 1'b0;
    end

    unique case (state_q)
      S_RST: begin
        if (rst_cnt_q == RST_CW'(RST_CYCLES - 1)) state_d = S_IDLE;
        else rst_cnt_d = rst_cnt_q + RST_CW'(1);
      end
      S_FILL: begin
        if (mem_to_fifo_done) begin
          if (run_q) state_d = S_DRAIN;
          else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (fifo_to_arr_done) begin
          if (run_q) state_d = S_MULT;
          else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      S_MULT: begin
        if (output_done) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          run_d   = 1'b0;
        end
      end
      default: ;
    endcase

    if (cmd_wr) begin
      if (opcode == OP_RESET) begin
        state_d    = S_RST;
        rst_cnt_d  = '0;
        in_base_d  = '0;
        wt_base_d  = '0;
        out_base_d = '0;
        run_d      = 1'b0;
        accepted   = 1'b1;
      end else if (state_q != S_IDLE) begin
        err_d = 1'b1;
      end else begin
        case (opcode)
          OP_FILL: begin
            wt_base_d = base_a;
            state_d   = S_FILL;
            accepted  = 1'b1;
          end
          OP_DRAIN: begin
            state_d  = S_DRAIN;
            accepted = 1'b1;
          end
          OP_MULT: begin
            in_base_d  = base_a;
            out_base_d = base_b;
            state_d    = S_MULT;
            accepted   = 1'b1;
          end
          OP_RUN: begin
            wt_base_d  = base_a;
            in_base_d  = base_a;
            out_base_d = base_b;
            run_d      = 1'b1;
            state_d    = S_FILL;
            accepted   = 1'b1;
          end
          default: err_d = 1'b1;
        endcase
      end
    end

    if (accepted) begin
      done_d = 1'b0;
      err_d  = 1'b0;
    end

    if (accepted)                                   cycles_d = '0;
    else if ((state_q != S_IDLE) && (cycles_q != '1)) cycles_d = cycles_q + DATA_WIDTH'(1);
    else                                            cycles_d = cycles_q;
  end

  logic [7:0]            status_w;
  logic [DATA_WIDTH-1:0] ctrl_rdata;

  assign status_w = {1'b0, state_q, 1'b0, err_q, done_q, (state_q != S_IDLE)};

  always_comb begin
    ctrl_rdata = '0;
    case (offset)
      OFF_STATUS: ctrl_rdata = DATA_WIDTH'(status_w);
      OFF_CYCLES: ctrl_rdata = cycles_q;
      OFF_IRQEN:  ctrl_rdata = DATA_WIDTH'(irq_en_q);
      default:    ctrl_rdata = '0;
    endcase
  end

  logic                  rd_v1_q, rd_core1_q, rdv_q;
  logic [DATA_WIDTH-1:0] rd_data1_q, rdata_q;
  logic                  tpu_reset_q, fill_q, drain_q, active_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      run_q       <= 1'b0;
      rst_cnt_q   <= '0;
      in_base_q   <= '0;
      wt_base_q   <= '0;
      out_base_q  <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      irq_en_q    <= 1'b0;
      cycles_q    <= '0;
      rd_v1_q     <= 1'b0;
      rd_core1_q  <= 1'b0;
      rd_data1_q  <= '0;
      rdv_q       <= 1'b0;
      rdata_q     <= '0;
      tpu_reset_q <= 1'b0;
      fill_q      <= 1'b0;
      drain_q     <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      rst_cnt_q   <= rst_cnt_d;
      in_base_q   <= in_base_d;
      wt_base_q   <= wt_base_d;
      out_base_q  <= out_base_d;
      done_q      <= done_d;
      err_q       <= err_d;
      irq_en_q    <= irq_en_d;
      cycles_q    <= cycles_d;
      // Control registers are snapshotted at request time; core data one cycle later.
      rd_v1_q     <= slave_read;
      rd_core1_q  <= slave_read && (region == 2'b11);
      rd_data1_q  <= (slave_read && (region == 2'b00)) ? ctrl_rdata : '0;
      rdv_q       <= rd_v1_q;
      rdata_q     <= !rd_v1_q ? '0 : (rd_core1_q ? out_rd_data : rd_data1_q);
      tpu_reset_q <= (state_d == S_RST);
      fill_q      <= (state_d == S_FILL);
      drain_q     <= (state_d == S_DRAIN);
      active_q    <= (state_d == S_MULT);
    end
  end

  assign slave_readdata      = rdata_q;
  assign slave_readdatavalid = rdv_q;
  assign tpu_reset           = tpu_reset_q;
  assign fill_fifo           = fill_q;
  assign drain_fifo          = drain_q;
  assign active              = active_q;
  assign in_base             = {WIDTH_HEIGHT{in_base_q}};
  assign wt_base             = {WIDTH_HEIGHT{wt_base_q}};
  assign out_base            = {WIDTH_HEIGHT{out_base_q}};
  assign irq                 = done_q & irq_en_q;

endmodule

// File: tb/tb_tpu_avalon_ctrl.sv
// Bench for tpu_avalon_ctrl: directed scenarios plus random traffic, all compared
// against a cycle-level behavioural model of the register/command rules.
module tb_tpu_avalon_ctrl;
  localparam int unsigned DW = 64;
  localparam int unsigned WH = 16;
  localparam int unsigned AW = 8;
  localparam int unsigned RC = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [AW+1:0]     slave_address;
  logic              slave_read, slave_write;
  logic [DW-1:0]     slave_writedata, slave_readdata;
  logic              slave_readdatavalid, slave_waitrequest;
  logic [WH-1:0]     in_wr_en, wt_wr_en, out_rd_en;
  logic [WH*AW-1:0]  mem_wr_addr, out_rd_addr, in_base, wt_base, out_base;
  logic [WH*8-1:0]   mem_wr_data;
  logic [DW-1:0]     out_rd_data;
  logic              tpu_reset, fill_fifo, drain_fifo, active;
  logic              mem_to_fifo_done, fifo_to_arr_done, output_done, irq;

  tpu_avalon_ctrl #(.DATA_WIDTH(DW), .WIDTH_HEIGHT(WH), .MEM_AW(AW), .RST_CYCLES(RC)) dut (
    .clk(clk), .reset(reset), .slave_address(slave_address), .slave_read(slave_read),
    .slave_write(slave_write), .slave_writedata(slave_writedata), .slave_readdata(slave_readdata),
    .slave_readdatavalid(slave_readdatavalid), .slave_waitrequest(slave_waitrequest),
    .in_wr_en(in_wr_en), .wt_wr_en(wt_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .out_rd_en(out_rd_en), .out_rd_addr(out_rd_addr), .out_rd_data(out_rd_data),
    .tpu_reset(tpu_reset), .fill_fifo(fill_fifo), .drain_fifo(drain_fifo), .active(active),
    .in_base(in_base), .wt_base(wt_base), .out_base(out_base),
    .mem_to_fifo_done(mem_to_fifo_done), .fifo_to_arr_done(fifo_to_arr_done),
    .output_done(output_done), .irq(irq)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: state numbers are the STATUS[6:4] codes.
  localparam int ST_IDLE = 0, ST_RST = 1, ST_FILL = 2, ST_DRAIN = 3, ST_MULT = 4;

  typedef struct {
    int unsigned   due;
    int unsigned   rcyc;
    bit            from_core;
    logic [DW-1:0] data;
  } rd_t;

  int              m_state;
  int              m_rst_left;
  bit              m_run, m_done, m_err, m_irq_en;
  logic [7:0]      m_in_base, m_wt_base, m_out_base;
  longint unsigned m_cycles;
  rd_t             rq[$];
  int unsigned     cyc = 0;
  int unsigned     rst_seen = 0;
  logic [DW-1:0]   last_rd = '0;

  function automatic logic [127:0] rep8(input logic [7:0] v);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[i*8 +: 8] = v;
    return r;
  endfunction

  function automatic logic [DW-1:0] status_word();
    return DW'((m_state << 4) | (int'(m_err) << 2) | (int'(m_done) << 1) | int'(m_state != ST_IDLE));
  endfunction

  task automatic model_reset();
    m_state = ST_IDLE; m_rst_left = 0; m_run = 0; m_done = 0; m_err = 0; m_irq_en = 0;
    m_in_base = '0; m_wt_base = '0; m_out_base = '0; m_cycles = 0;
    rq.delete();
  endtask

  task automatic model_step();
    int         rg, off, pre;
    bit         accepted;
    logic [3:0] op;
    rg  = int'(slave_address[AW+1:AW]);
    off = int'(slave_address[AW-1:0]);
    pre = m_state;
    accepted = 0;
    op = slave_writedata[3:0];
    foreach (rq[i]) if (rq[i].from_core && rq[i].rcyc + 1 == cyc) rq[i].data = out_rd_data;
    if (slave_read) begin
      rd_t e;
      e.due = cyc + 2; e.rcyc = cyc; e.from_core = (rg == 3); e.data = '0;
      if (rg == 0) begin
        if (off == 1) e.data = status_word();
        else if (off == 2) e.data = m_cycles;
        else if (off == 3) e.data = DW'(m_irq_en);
      end
      rq.push_back(e);
    end
    if (slave_write && rg == 0 && off == 3) m_irq_en = slave_writedata[0];
    if (slave_write && rg == 0 && off == 1) begin m_done = 0; m_err = 0; end
    if (pre == ST_RST) begin
      m_rst_left--;
      if (m_rst_left == 0) m_state = ST_IDLE;
    end else if (pre == ST_FILL && mem_to_fifo_done) begin
      if (m_run) m_state = ST_DRAIN; else begin m_state = ST_IDLE; m_done = 1; end
    end else if (pre == ST_DRAIN && fifo_to_arr_done) begin
      if (m_run) m_state = ST_MULT; else begin m_state = ST_IDLE; m_done = 1; end
    end else if (pre == ST_MULT && output_done) begin
      m_state = ST_IDLE; m_done = 1; m_run = 0;
    end
    if (slave_write && rg == 0 && off == 0) begin
      if (op == 4'hF) begin
        m_state = ST_RST; m_rst_left = RC; m_run = 0; accepted = 1;
        m_in_base = '0; m_wt_base = '0; m_out_base = '0;
      end else if (pre != ST_IDLE || op == 4'h0 || op > 4'h4) begin
        m_err = 1;
      end else begin
        accepted = 1;
        case (op)
          4'h1: begin m_wt_base = slave_writedata[11:4]; m_state = ST_FILL; end
          4'h2: m_state = ST_DRAIN;
          4'h3: begin m_in_base = slave_writedata[11:4]; m_out_base = slave_writedata[19:12]; m_state = ST_MULT; end
          default: begin
            m_wt_base = slave_writedata[11:4]; m_in_base = slave_writedata[11:4];
            m_out_base = slave_writedata[19:12]; m_run = 1; m_state = ST_FILL;
          end
        endcase
      end
    end
    if (accepted) begin m_done = 0; m_err = 0; m_cycles = 0; end
    else if (pre != ST_IDLE && m_cycles != 64'hFFFF_FFFF_FFFF_FFFF) m_cycles++;
  endtask

  task automatic check_outputs();
    int rg;
    bit exp_v;
    rg = int'(slave_address[AW+1:AW]);
    check_eq("in_wr_en", in_wr_en, (slave_write && rg == 1) ? 128'hFFFF : 128'h0);
    check_eq("wt_wr_en", wt_wr_en, (slave_write && rg == 2) ? 128'hFFFF : 128'h0);
    check_eq("mem_wr_addr", mem_wr_addr, rep8(slave_address[AW-1:0]));
    check_eq("mem_wr_data", mem_wr_data, rep8(slave_writedata[7:0]));
    check_eq("out_rd_en", out_rd_en, (slave_read && rg == 3) ? 128'hFFFF : 128'h0);
    check_eq("out_rd_addr", out_rd_addr, rep8(slave_address[AW-1:0]));
    check_eq("ctl", {tpu_reset, fill_fifo, drain_fifo, active},
             {m_state == ST_RST, m_state == ST_FILL, m_state == ST_DRAIN, m_state == ST_MULT});
    check_eq("in_base", in_base, rep8(m_in_base));
    check_eq("wt_base", wt_base, rep8(m_wt_base));
    check_eq("out_base", out_base, rep8(m_out_base));
    check_eq("irq", irq, m_done & m_irq_en);
    check_eq("waitreq", slave_waitrequest, 0);
    exp_v = (rq.size() != 0) && (rq[0].due == cyc);
    check_eq("rdvalid", slave_readdatavalid, exp_v);
    if (exp_v) begin
      check_eq("rdata", slave_readdata, rq[0].data);
      last_rd = slave_readdata;
      void'(rq.pop_front());
    end
    if (tpu_reset) rst_seen++;
  endtask

  task automatic cycle();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    if (!reset) model_reset(); else model_step();
    cyc++;
    #1;
    out_rd_data = {$urandom, $urandom};
  endtask

  task automatic set_idle();
    slave_read = 0; slave_write = 0; slave_address = '0; slave_writedata = '0;
    mem_to_fifo_done = 0; fifo_to_arr_done = 0; output_done = 0;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) cycle();
  endtask

  task automatic do_write(input logic [1:0] rg, input logic [7:0] off, input logic [DW-1:0] d);
    slave_write = 1; slave_address = {rg, off}; slave_writedata = d;
    cycle();
    set_idle();
  endtask

  task automatic do_read(input logic [1:0] rg, input logic [7:0] off);
    slave_read = 1; slave_address = {rg, off};
    cycle();
    set_idle();
  endtask

  initial begin
    logic [DW-1:0] wd;
    logic [3:0]    ops [6];
    int            r;
    ops[0] = 4'h1; ops[1] = 4'h2; ops[2] = 4'h3; ops[3] = 4'h4; ops[4] = 4'hF; ops[5] = 4'h0;

    reset = 0; set_idle(); out_rd_data = '0; model_reset();
    @(posedge clk); #1;
    idle(2);
    check_eq("rst_ctl", {tpu_reset, fill_fifo, drain_fifo, active}, 4'b0000);
    reset = 1;
    idle(3);

    // Memory write fan-out, zero latency
    slave_write = 1; slave_address = {2'b01, 8'h05}; slave_writedata = 64'hAB;
    #1;
    check_eq("req18_in_wr_en", in_wr_en, 16'hFFFF);
    check_eq("req18_wt_wr_en", wt_wr_en, 16'h0000);
    check_eq("req18_wr_data", mem_wr_data, rep8(8'hAB));
    cycle(); set_idle();
    do_write(2'b11, 8'h10, 64'h55);

    // RUN sequence with interrupt enabled
    do_write(2'b00, 8'h03, 64'h1);
    do_write(2'b00, 8'h00, 64'h2014);
    idle(2);
    check_eq("req19_fill", fill_fifo, 1);
    check_eq("req19_wt_base", wt_base[7:0], 8'h01);
    mem_to_fifo_done = 1; cycle(); set_idle(); idle(1);
    check_eq("req19_drain", drain_fifo, 1);
    fifo_to_arr_done = 1; cycle(); set_idle(); idle(1);
    check_eq("req19_active", active, 1);
    check_eq("req19_in_base", in_base[7:0], 8'h01);
    check_eq("req19_out_base", out_base[7:0], 8'h02);
    output_done = 1; cycle(); set_idle(); idle(1);
    check_eq("req19_irq", irq, 1);
    do_read(2'b00, 8'h01); idle(2);
    check_eq("req19_status", last_rd, 64'h2);
    do_read(2'b11, 8'h03); idle(2);

    // Command while busy, then RESET
    do_write(2'b00, 8'h00, 64'h0_05_07_3);
    do_write(2'b00, 8'h00, 64'h0_00_09_1);
    check_eq("req20_active", active, 1);
    do_read(2'b00, 8'h01); idle(2);
    check_eq("req20_status_err", last_rd, 64'h45);
    rst_seen = 0;
    do_write(2'b00, 8'h00, 64'hF);
    idle(8);
    check_eq("req20_rst_len", rst_seen, RC);
    do_read(2'b00, 8'h01); idle(2);
    check_eq("req20_status", last_rd, 64'h0);

    // Asynchronous reset in the middle of DRAIN
    do_write(2'b00, 8'h00, 64'h2);
    idle(3);
    check_eq("req22_drain_pre", drain_fifo, 1);
    #2 reset = 0;
    #1 check_eq("req22_drain_async", drain_fifo, 0);
    model_reset();
    idle(2);
    reset = 1;
    idle(3);
    do_read(2'b00, 8'h02); idle(2);
    check_eq("req22_cycles", last_rd, 64'h0);

    // Random traffic
    for (int unsigned n = 0; n < 3000; n++) begin
      set_idle();
      r = $urandom_range(0, 99);
      wd = {$urandom, $urandom};
      if (r < 15) begin
        wd[3:0] = ops[$urandom_range(0, 5)];
        slave_write = 1; slave_address = {2'b00, 8'h00}; slave_writedata = wd;
      end else if (r < 19) begin
        slave_write = 1; slave_address = {2'b00, 8'h01}; slave_writedata = wd;
      end else if (r < 23) begin
        slave_write = 1; slave_address = {2'b00, 8'h03}; slave_writedata = wd;
      end else if (r < 33) begin
        slave_write = 1; slave_address = {2'($urandom_range(1, 3)), 8'($urandom)}; slave_writedata = wd;
      end else if (r < 43) begin
        slave_read = 1; slave_address = {2'b00, 8'($urandom_range(0, 4))};
      end else if (r < 53) begin
        slave_read = 1; slave_address = {2'($urandom_range(1, 3)), 8'($urandom)};
      end
      mem_to_fifo_done = ($urandom_range(0, 7) == 0);
      fifo_to_arr_done = ($urandom_range(0, 7) == 0);
      output_done      = ($urandom_range(0, 7) == 0);
      cycle();
    end
    set_idle();
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
